// File: rtl/a2bus_timing_pkg.sv
// Shared constants, payload types and helpers for the Apple II bus timing generator.
// The constants cover tick counts per CPU cycle, cycles per line and the
// phi0 / Q3 tick boundaries. The helpers map a tick index to output levels.
package a2bus_timing_pkg;

    localparam int unsigned TICKS_NORMAL    = 14;
    localparam int unsigned TICKS_LONG      = 16;
    localparam int unsigned CYCLES_PER_LINE = 65;
    localparam int unsigned PHI0_HIGH_TICKS = 7;
    localparam int unsigned Q3_FALL0        = 4;
    localparam int unsigned Q3_RISE1        = 7;
    localparam int unsigned Q3_FALL1        = 11;

    localparam int unsigned T_W     = 4;
    localparam int unsigned CYCLE_W = 7;

    // The reset point is the last tick of the last cycle, so the first tick lands on cycle 0, t=0.
    localparam logic [T_W-1:0]     T_RESET    = T_W'(TICKS_LONG - 1);
    localparam logic [CYCLE_W-1:0] CYCLE_LAST = CYCLE_W'(CYCLES_PER_LINE - 1);

    // Registered clock levels.
    typedef struct packed {
        logic phi0;
        logic phi1;
        logic q3;
        logic clk7m;
    } a2_levels_t;

    // One-clock edge strobes.
    typedef struct packed {
        logic phi0_pos;
        logic phi0_neg;
        logic phi1_pos;
        logic phi1_neg;
        logic q3_pos;
        logic q3_neg;
        logic clk7m_pos;
        logic clk7m_neg;
        logic tick;
    } a2_strobes_t;

    localparam a2_levels_t LEVELS_RESET = '{phi0: 1'b0, phi1: 1'b1, q3: 1'b0, clk7m: 1'b0};

    // Final tick index of the given cycle. Only the last cycle of a line can be stretched.
    function automatic logic [T_W-1:0] last_tick(input logic [CYCLE_W-1:0] cyc,
                                                 input logic               long_en);
        if (long_en && (cyc == CYCLE_LAST)) begin
            return T_W'(TICKS_LONG - 1);
        end
        return T_W'(TICKS_NORMAL - 1);
    endfunction

    // Compute the phi0/phi1/Q3 levels for tick index t; the 7M level is passed through.
    function automatic a2_levels_t levels_at(input logic [T_W-1:0] t, input logic clk7m);
        a2_levels_t lv;
        lv.phi0  = (t < T_W'(PHI0_HIGH_TICKS));
        lv.phi1  = ~lv.phi0;
        lv.q3    = (t < T_W'(Q3_FALL0)) ||
                   ((t >= T_W'(Q3_RISE1)) && (t < T_W'(Q3_FALL1)));
        lv.clk7m = clk7m;
        return lv;
    endfunction

endpackage : a2bus_timing_pkg

// File: rtl/a2bus_tick_nco.sv
// Phase-accumulator tick generator. It produces the 14M master tick from an
// arbitrary logic clock with no long-term drift.
//   clk_logic_i : logic clock
//   rst_n_i     : asynchronous active-low reset (accumulator cleared)
//   enable_i    : 1 = accumulate, 0 = hold accumulator, no ticks
//   tick_c_o    : combinational tick, high on the clock whose edge completes a 14M period
module a2bus_tick_nco #(
    parameter int unsigned CLOCK_SPEED_HZ = 54_000_000,
    parameter int unsigned APPLE_HZ       = 14_318_181
) (
    input  logic clk_logic_i,
    input  logic rst_n_i,
    input  logic enable_i,
    output logic tick_c_o
);

    // Wide enough for acc+step, whose maximum is below CLOCK_SPEED_HZ+APPLE_HZ.
    localparam int unsigned ACC_W = $clog2(CLOCK_SPEED_HZ + APPLE_HZ + 1);
    localparam logic [ACC_W-1:0] STEP  = ACC_W'(APPLE_HZ);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLOCK_SPEED_HZ);

    // At least two logic clocks per tick keeps strobes off adjacent clocks.
    if (CLOCK_SPEED_HZ < 2 * APPLE_HZ) begin : g_bad_ratio
        $error("a2bus_tick_nco: CLOCK_SPEED_HZ must be at least 2*APPLE_HZ");
    end

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum_c;

    // Next accumulator value and tick decision.
    always_comb begin
        sum_c    = acc_q + STEP;
        acc_d    = acc_q;
        tick_c_o = 1'b0;
        if (enable_i) begin
            if (sum_c >= LIMIT) begin
                tick_c_o = 1'b1;
                acc_d    = sum_c - LIMIT;
            end else begin
                acc_d = sum_c;
            end
        end
    end

    // Accumulator register.
    always_ff @(posedge clk_logic_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule : a2bus_tick_nco

// File: rtl/a2bus_timing_gen.sv
// Apple II bus timing generator. It synthesizes phi0/phi1/Q3/7M and the 14M
// strobe from a fast logic clock. There are 14 ticks per CPU cycle and
// 65 cycles per line. The last cycle of a line can be stretched to 16 ticks.
//   clk_logic_i            : logic clock
//   rst_n_i                : asynchronous active-low reset
//   enable_i               : 1 = run, 0 = freeze state and suppress strobes
//   phi0_o / phi1_o / q3_o / clk_7M_o : registered clock levels
//   *_posedge_o / *_negedge_o          : one-clock strobes, coincident with the level change
//   clk_14M_posedge_o      : one-clock strobe per 14M tick
//   cycle_o                : CPU-cycle index within the line (0..64)
module a2bus_timing_gen
    import a2bus_timing_pkg::*;
#(
    parameter int unsigned CLOCK_SPEED_HZ    = 54_000_000,
    parameter int unsigned APPLE_HZ          = 14_318_181,
    parameter int unsigned ENABLE_LONG_CYCLE = 1
) (
    input  logic               clk_logic_i,
    input  logic               rst_n_i,
    input  logic               enable_i,
    output logic               phi0_o,
    output logic               phi0_posedge_o,
    output logic               phi0_negedge_o,
    output logic               phi1_o,
    output logic               phi1_posedge_o,
    output logic               phi1_negedge_o,
    output logic               q3_o,
    output logic               q3_posedge_o,
    output logic               q3_negedge_o,
    output logic               clk_7M_o,
    output logic               clk_7M_posedge_o,
    output logic               clk_7M_negedge_o,
    output logic               clk_14M_posedge_o,
    output logic [CYCLE_W-1:0] cycle_o
);

    localparam logic LONG_EN = (ENABLE_LONG_CYCLE != 0);

    logic tick_c;

    a2bus_tick_nco #(
        .CLOCK_SPEED_HZ (CLOCK_SPEED_HZ),
        .APPLE_HZ       (APPLE_HZ)
    ) u_nco (
        .clk_logic_i (clk_logic_i),
        .rst_n_i     (rst_n_i),
        .enable_i    (enable_i),
        .tick_c_o    (tick_c)
    );

    logic [T_W-1:0]     t_q;
    logic [T_W-1:0]     t_d;
    logic [CYCLE_W-1:0] cycle_q;
    logic [CYCLE_W-1:0] cycle_d;
    a2_levels_t         lvl_q;
    a2_levels_t         lvl_d;
    a2_strobes_t        stb_q;
    a2_strobes_t        stb_d;

    // Tick/cycle advance and level/strobe generation; state holds when there is no tick.
    always_comb begin
        t_d     = t_q;
        cycle_d = cycle_q;
        lvl_d   = lvl_q;
        stb_d   = '0;
        if (tick_c) begin
            // Use >= so the reset value (t=15) also wraps when the long cycle is disabled.
            if (t_q >= last_tick(cycle_q, LONG_EN)) begin
                t_d     = '0;
                cycle_d = (cycle_q >= CYCLE_LAST) ? '0 : cycle_q + CYCLE_W'(1);
            end else begin
                t_d = t_q + T_W'(1);
            end
            lvl_d = levels_at(t_d, ~lvl_q.clk7m);

            stb_d.tick      = 1'b1;
            stb_d.phi0_pos  =  lvl_d.phi0  & ~lvl_q.phi0;
            stb_d.phi0_neg  = ~lvl_d.phi0  &  lvl_q.phi0;
            stb_d.phi1_pos  =  lvl_d.phi1  & ~lvl_q.phi1;
            stb_d.phi1_neg  = ~lvl_d.phi1  &  lvl_q.phi1;
            stb_d.q3_pos    =  lvl_d.q3    & ~lvl_q.q3;
            stb_d.q3_neg    = ~lvl_d.q3    &  lvl_q.q3;
            stb_d.clk7m_pos =  lvl_d.clk7m & ~lvl_q.clk7m;
            stb_d.clk7m_neg = ~lvl_d.clk7m &  lvl_q.clk7m;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_logic_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            t_q     <= T_RESET;
            cycle_q <= CYCLE_LAST;
            lvl_q   <= LEVELS_RESET;
            stb_q   <= '0;
        end else begin
            t_q     <= t_d;
            cycle_q <= cycle_d;
            lvl_q   <= lvl_d;
            stb_q   <= stb_d;
        end
    end

    assign phi0_o            = lvl_q.phi0;
    assign phi0_posedge_o    = stb_q.phi0_pos;
    assign phi0_negedge_o    = stb_q.phi0_neg;
    assign phi1_o            = lvl_q.phi1;
    assign phi1_posedge_o    = stb_q.phi1_pos;
    assign phi1_negedge_o    = stb_q.phi1_neg;
    assign q3_o              = lvl_q.q3;
    assign q3_posedge_o      = stb_q.q3_pos;
    assign q3_negedge_o      = stb_q.q3_neg;
    assign clk_7M_o          = lvl_q.clk7m;
    assign clk_7M_posedge_o  = stb_q.clk7m_pos;
    assign clk_7M_negedge_o  = stb_q.clk7m_neg;
    assign clk_14M_posedge_o = stb_q.tick;
    assign cycle_o           = cycle_q;

endmodule : a2bus_timing_gen

// File: doc/a2bus_timing_gen.md
A2BUS_TIMING_GEN -- requirements
Module: a2bus_timing_gen

Interface
REQ-001 SHALL have parameter CLOCK_SPEED_HZ, default 54_000_000: frequency of clk_logic_i.
REQ-002 SHALL have parameter APPLE_HZ, default 14_318_181: target 14M master-tick rate.
REQ-003 SHALL have parameter ENABLE_LONG_CYCLE, default 1: 1 = stretch last CPU cycle of each line.
REQ-004 SHALL have port clk_logic_i, input, 1: the single clock; every register is clocked on its rising edge.
REQ-005 SHALL have port rst_n_i, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port enable_i, input, 1: 1 = run timing chain, 0 = freeze.
REQ-007 SHALL have ports phi0_o, phi0_posedge_o, phi0_negedge_o, outputs, 1 each: synthesized phi0 level and edge strobes.
REQ-008 SHALL have ports phi1_o, phi1_posedge_o, phi1_negedge_o, outputs, 1 each: phi1 level and edge strobes.
REQ-009 SHALL have ports q3_o, q3_posedge_o, q3_negedge_o, outputs, 1 each: Q3 level and edge strobes.
REQ-010 SHALL have ports clk_7M_o, clk_7M_posedge_o, clk_7M_negedge_o, outputs, 1 each: 7M level and edge strobes.
REQ-011 SHALL have port clk_14M_posedge_o, output, 1: one-cycle strobe per 14M tick.
REQ-012 SHALL have port cycle_o, output, 7: CPU-cycle index within the line.

Function
REQ-013 SHALL generate ticks with a phase accumulator: each enabled clock, acc+APPLE_HZ >= CLOCK_SPEED_HZ -> tick, acc <= acc+APPLE_HZ-CLOCK_SPEED_HZ; otherwise acc <= acc+APPLE_HZ.
REQ-014 SHALL fail elaboration unless CLOCK_SPEED_HZ >= 2*APPLE_HZ, so strobes never occur on adjacent clocks.
REQ-015 SHALL size acc to hold CLOCK_SPEED_HZ+APPLE_HZ without overflow; no long-term drift.
REQ-016 SHALL advance tick index t on each tick: 0..13 in normal cycles, 0..15 in the long cycle; wrap to 0 increments cycle_o.
REQ-017 SHALL wrap cycle_o 0..64; cycle 64 is long only if ENABLE_LONG_CYCLE=1.
REQ-018 SHALL drive phi0_o=1 for t=0..6 and 0 for t=7..end of cycle; phi1_o = ~phi0_o always.
REQ-019 SHALL drive q3_o=1 for t=0..3 and 7..10; 0 for t=4..6 and 11..end of cycle.
REQ-020 SHALL toggle clk_7M_o on every tick.
REQ-021 SHALL register all outputs; each strobe is high exactly on the clock its level output first shows the new value; otherwise 0.
REQ-022 SHALL assert clk_14M_posedge_o on every clock where t changes; it equals clk_7M_posedge_o | clk_7M_negedge_o.
REQ-023 SHALL, with enable_i=0, freeze acc, t, cycle_o and levels, and force all strobes to 0; resume seamlessly when re-enabled.

Reset
REQ-024 SHALL on rst_n_i low asynchronously set: acc=0, t=15, cycle_o=64, phi0_o=0, phi1_o=1, q3_o=0, clk_7M_o=0, all strobes 0.
REQ-025 SHALL cause the first tick after reset release to enter cycle_o=0, t=0 (phi0, q3 and 7M rising together).
REQ-026 SHALL abandon any partial cycle on reset assertion mid-operation; no glitch strobes on release.

Structure
REQ-027 SHALL place TICKS_NORMAL=14, TICKS_LONG=16, CYCLES_PER_LINE=65, PHI0_HIGH_TICKS=7 and the Q3 boundaries (4, 7, 11) in package a2bus_timing_pkg.
REQ-028 SHALL isolate the accumulator in sub-module a2bus_tick_nco (inputs clock, reset, enable; output tick).

Verification
REQ-029 SHALL check: CLOCK_SPEED_HZ=4, APPLE_HZ=1, enable=1 after reset -> clk_14M_posedge_o every 4th clock; first tick gives phi0_posedge_o, q3_posedge_o, clk_7M_posedge_o together with cycle_o=0.
REQ-030 SHALL check: normal cycle -> phi0 high 7 ticks, low 7; q3 high 4, low 3, high 4, low 3; seven clk_7M_posedge_o.
REQ-031 SHALL check: ENABLE_LONG_CYCLE=1 -> cycle 64 has 16 ticks with phi0 low 9; one full line = 912 ticks. With 0 -> every line = 910 ticks.
REQ-032 SHALL check: defaults, 54,000 clocks from reset -> exactly 14,318 clk_14M_posedge_o; no two strobes on adjacent clocks.
REQ-033 SHALL check: enable_i low for 10 clocks mid-cycle -> levels held, zero strobes, t/cycle_o unchanged; tick spacing continues unchanged after re-enable.
REQ-034 SHALL check: rst_n_i asserted at t=5 of cycle 30 -> outputs immediately at REQ-024 values; restart per REQ-025.
